// File: rtl/dec_dig_blck_builder_if.sv
// Bus bundle for dec_dig_blck_builder: feed load, ciphertext in, plaintext out, digest out.
// No logic or latency of its own; it only carries wires.
// Handshakes are valid/ready; the master side is the block's environment.
//
// master : driven by the environment (feed, ciphertext words, pt_ready, dig_blck_ready)
// slave  : the block builder itself (din_ready, plaintext, digest)
interface dec_dig_blck_builder_if #(
  parameter int BLCK_SIZE = 256,
  parameter int BUS_SIZE  = 32
);
  // keystream block load
  logic [BLCK_SIZE-1:0]  feed_blck_in;
  logic                  feed_load;
  // ciphertext input stream
  logic [BUS_SIZE-1:0]   din;
  logic [BUS_SIZE/8-1:0] din_validity;
  logic                  din_valid;
  logic                  din_ready;
  logic                  din_last;
  // plaintext output stream
  logic [BUS_SIZE-1:0]   pt_out;
  logic [BUS_SIZE/8-1:0] pt_validity;
  logic                  pt_valid;
  logic                  pt_ready;
  // formatted digest block
  logic [BLCK_SIZE-1:0]  dig_blck_out;
  logic                  dig_blck_full;
  logic                  dig_blck_valid;
  logic                  dig_blck_ready;

  modport master (
    output feed_blck_in, feed_load,
    output din, din_validity, din_valid, din_last,
    output pt_ready, dig_blck_ready,
    input  din_ready,
    input  pt_out, pt_validity, pt_valid,
    input  dig_blck_out, dig_blck_full, dig_blck_valid
  );

  modport slave (
    input  feed_blck_in, feed_load,
    input  din, din_validity, din_valid, din_last,
    input  pt_ready, dig_blck_ready,
    output din_ready,
    output pt_out, pt_validity, pt_valid,
    output dig_blck_out, dig_blck_full, dig_blck_valid
  );
endinterface

// File: rtl/dec_dig_blck_builder.sv
// Decryption block builder: XORs ciphertext words with a keystream block, builds the digest block.
// Latency: plaintext 1 cycle after accept; digest valid 1 cycle after the final word is accepted.
// Backpressure: pt_ready low stalls din_ready combinationally; digest is held until dig_blck_ready.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset, clears every register
//   bus  : dec_dig_blck_builder_if.slave (feed load, din stream, pt stream, digest handshake)
// Optional feature macro: DEC_DIG_PAD_EN -- when defined, the first invalid digest byte is
// the feed byte XOR 0x01 (no pad byte when the whole block is valid).
module dec_dig_blck_builder #(
  parameter int BLCK_SIZE = 256,
  parameter int BUS_SIZE  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  dec_dig_blck_builder_if.slave bus
);

  localparam int NW    = BLCK_SIZE / BUS_SIZE;  // words per block
  localparam int NB    = BLCK_SIZE / 8;         // bytes per block
  localparam int WB    = BUS_SIZE / 8;          // bytes per word
  localparam int CNT_W = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NW - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // state and datapath registers
  state_t                state_q,   state_d;
  logic [BLCK_SIZE-1:0]  feed_q,    feed_d;
  logic [BLCK_SIZE-1:0]  ct_q,      ct_d;
  logic [NB-1:0]         vld_q,     vld_d;
  logic [CNT_W-1:0]      cnt_q,     cnt_d;
  logic [BUS_SIZE-1:0]   pt_q,      pt_d;
  logic [WB-1:0]         ptv_q,     ptv_d;
  logic                  pt_vld_q,  pt_vld_d;
  logic                  dig_vld_q, dig_vld_d;

  logic                  din_rdy;
  logic                  accept;
  logic [BUS_SIZE-1:0]   feed_wrd;
  logic [BLCK_SIZE-1:0]  dig_blck;

  // A word may enter only if the plaintext register is free or draining this cycle.
  assign din_rdy = (state_q == ST_FILL) & (~pt_vld_q | bus.pt_ready);
  assign accept  = bus.din_valid & din_rdy;

  // Keystream word aligned with the slot the next accepted word lands in.
  assign feed_wrd = feed_q[cnt_q*BUS_SIZE +: BUS_SIZE];

  // Next-state logic for the FSM and all buffers.
  always_comb begin
    state_d   = state_q;
    feed_d    = feed_q;
    ct_d      = ct_q;
    vld_d     = vld_q;
    cnt_d     = cnt_q;
    dig_vld_d = dig_vld_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.feed_load) begin
          feed_d  = bus.feed_blck_in;
          ct_d    = '0;
          vld_d   = '0;
          cnt_d   = '0;
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        if (accept) begin
          ct_d[cnt_q*BUS_SIZE +: BUS_SIZE] = bus.din;
          vld_d[cnt_q*WB +: WB]            = bus.din_validity;
          cnt_d                            = cnt_q + CNT_W'(1);
          // End of block on explicit last or on the final slot, whichever comes first.
          if (bus.din_last || (cnt_q == CNT_LAST)) begin
            state_d   = ST_DONE;
            dig_vld_d = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (dig_vld_q && bus.dig_blck_ready) begin
          state_d   = ST_IDLE;
          dig_vld_d = 1'b0;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        dig_vld_d = 1'b0;
      end
    endcase
  end

  // Plaintext register: loads on accept, drains independently of the FSM.
  always_comb begin
    pt_d     = pt_q;
    ptv_d    = ptv_q;
    pt_vld_d = pt_vld_q;
    if (accept) begin
      pt_d     = bus.din ^ feed_wrd;
      ptv_d    = bus.din_validity;
      pt_vld_d = 1'b1;
    end else if (bus.pt_ready) begin
      pt_vld_d = 1'b0;
    end
  end

`ifdef DEC_DIG_PAD_EN
  // Validity is contiguous from byte 0 across the block, so the pad byte (index = valid
  // byte count) is the first invalid byte whose predecessor is valid; byte 0 has an
  // implicit valid predecessor. A full block has no such byte.
  logic [NB-1:0] vld_prev;
  logic [NB-1:0] pad_sel;
  assign vld_prev = {vld_q[NB-2:0], 1'b1};
  // Pad only while the digest is presented so that the idle/reset digest reads as zero.
  assign pad_sel  = ~vld_q & vld_prev & {NB{dig_vld_q}};
`endif

  // Per-byte digest mux: ciphertext where valid, keystream elsewhere.
  always_comb begin
    dig_blck = '0;
    for (int i = 0; i < NB; i++) begin
      if (vld_q[i]) begin
        dig_blck[i*8 +: 8] = ct_q[i*8 +: 8];
      end else begin
        dig_blck[i*8 +: 8] = feed_q[i*8 +: 8];
      end
`ifdef DEC_DIG_PAD_EN
      if (pad_sel[i]) begin
        dig_blck[i*8 +: 8] = feed_q[i*8 +: 8] ^ 8'h01;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      feed_q    <= '0;
      ct_q      <= '0;
      vld_q     <= '0;
      cnt_q     <= '0;
      pt_q      <= '0;
      ptv_q     <= '0;
      pt_vld_q  <= 1'b0;
      dig_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      feed_q    <= feed_d;
      ct_q      <= ct_d;
      vld_q     <= vld_d;
      cnt_q     <= cnt_d;
      pt_q      <= pt_d;
      ptv_q     <= ptv_d;
      pt_vld_q  <= pt_vld_d;
      dig_vld_q <= dig_vld_d;
    end
  end

  assign bus.din_ready      = din_rdy;
  assign bus.pt_out         = pt_q;
  assign bus.pt_validity    = ptv_q;
  assign bus.pt_valid       = pt_vld_q;
  assign bus.dig_blck_out   = dig_blck;
  assign bus.dig_blck_full  = &vld_q;
  assign bus.dig_blck_valid = dig_vld_q;

endmodule

// File: tb/tb_dec_dig_blck_builder.sv
// Directed bench for dec_dig_blck_builder with a plaintext scoreboard.
// Expected plaintext words are queued as stimulus is driven and popped as pt handshakes occur.
// Digest values are rebuilt from the stimulus constants in each scenario.
module tb_dec_dig_blck_builder;

  localparam int BLCK = 256;
  localparam int BUS  = 32;
`ifdef DEC_DIG_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  logic [35:0] sb[$];
  logic [35:0] exp_pt;

  dec_dig_blck_builder_if #(.BLCK_SIZE(BLCK), .BUS_SIZE(BUS)) bus ();

  dec_dig_blck_builder #(.BLCK_SIZE(BLCK), .BUS_SIZE(BUS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Plaintext scoreboard: compare on every completed pt handshake.
  always @(negedge clk) begin
    if (!rst && bus.pt_valid && bus.pt_ready) begin
      n_chk++;
      assert (sb.size() > 0) else begin
        n_fail++;
        $error("FAIL pt_extra observed=%0h expected=none", bus.pt_out);
      end
      if (sb.size() > 0) begin
        exp_pt = sb.pop_front();
        check("pt_word", {bus.pt_validity, bus.pt_out}, {220'd0, exp_pt});
      end
    end
  end

  // Called at posedge+1: present feed for one edge.
  task automatic load_feed(input logic [255:0] f);
    bus.feed_blck_in = f;
    bus.feed_load    = 1'b1;
    @(posedge clk); #1;
    bus.feed_load    = 1'b0;
    @(negedge clk);
    check("din_rdy_after_load", bus.din_ready, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic drive_word(input logic [31:0] d, input logic [3:0] v, input logic l,
                            input logic [31:0] fw);
    bus.din          = d;
    bus.din_validity = v;
    bus.din_last     = l;
    bus.din_valid    = 1'b1;
    sb.push_back({v, d ^ fw});
  endtask

  // Returns at posedge+1 of the accepting edge.
  task automatic wait_accept();
    logic got;
    got = 1'b0;
    for (int t = 0; t < 50 && !got; t++) begin
      @(negedge clk);
      if (bus.din_ready) got = 1'b1;
    end
    check("din_accept", got, 1'b1);
    @(posedge clk); #1;
    bus.din_valid = 1'b0;
    bus.din_last  = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d, input logic [3:0] v, input logic l,
                           input logic [31:0] fw);
    drive_word(d, v, l, fw);
    wait_accept();
  endtask

  // Called in the cycle right after the final accept.
  task automatic finish_digest(input string tag, input logic [255:0] exp, input logic full);
    @(negedge clk);
    check({tag, "_dig_vld"}, bus.dig_blck_valid, 1'b1);
    check({tag, "_dig_out"}, bus.dig_blck_out, exp);
    check({tag, "_dig_full"}, bus.dig_blck_full, full);
    bus.dig_blck_ready = 1'b1;
    @(posedge clk); #1;
    bus.dig_blck_ready = 1'b0;
    @(negedge clk);
    check({tag, "_dig_drop"}, bus.dig_blck_valid, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic run_full(input string tag);
    load_feed({32{8'hAA}});
    for (int k = 0; k < 8; k++) begin
      if (k == 7) check({tag, "_dig_early"}, bus.dig_blck_valid, 1'b0);
      send_word(32'h55555555, 4'hF, 1'b0, 32'hAAAAAAAA);
      if (k == 0) check({tag, "_pt_lat"}, bus.pt_valid, 1'b1);
    end
    finish_digest(tag, {32{8'h55}}, 1'b1);
  endtask

  initial begin
    logic [255:0] exp;
    logic [255:0] f;
    logic [31:0]  d[8];

    bus.feed_blck_in   = '0;
    bus.feed_load      = 1'b0;
    bus.din            = '0;
    bus.din_validity   = '0;
    bus.din_valid      = 1'b0;
    bus.din_last       = 1'b0;
    bus.pt_ready       = 1'b1;
    bus.dig_blck_ready = 1'b0;

    // Reset state
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_din_ready", bus.din_ready, 1'b0);
    check("rst_pt_valid", bus.pt_valid, 1'b0);
    check("rst_pt_out", bus.pt_out, 32'h0);
    check("rst_pt_validity", bus.pt_validity, 4'h0);
    check("rst_dig_valid", bus.dig_blck_valid, 1'b0);
    check("rst_dig_full", bus.dig_blck_full, 1'b0);
    check("rst_dig_out", bus.dig_blck_out, 256'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Full block
    run_full("full");

    // Partial block: 3 full words + 2-byte word with last
    load_feed({32{8'h22}});
    for (int k = 0; k < 3; k++) send_word(32'h11111111, 4'hF, 1'b0, 32'h22222222);
    send_word(32'h11111111, 4'h3, 1'b1, 32'h22222222);
    for (int i = 0; i < 32; i++) exp[i*8 +: 8] = (i < 14) ? 8'h11 : 8'h22;
    if (PAD) exp[14*8 +: 8] = 8'h23;
    finish_digest("partial", exp, 1'b0);

    // Empty block
    load_feed({32{8'h22}});
    send_word(32'hDEADBEEF, 4'h0, 1'b1, 32'h22222222);
    exp = {32{8'h22}};
    if (PAD) exp[7:0] = 8'h23;
    finish_digest("empty", exp, 1'b0);

    // Backpressure: pt_ready low 3 cycles mid-block, dig_blck_ready low 5 cycles
    for (int i = 0; i < 32; i++) f[i*8 +: 8] = 8'(i);
    for (int k = 0; k < 8; k++) d[k] = 32'h9E3779B9 * (k + 1);
    for (int k = 0; k < 8; k++) exp[k*32 +: 32] = d[k];
    load_feed(f);
    for (int k = 0; k < 4; k++) send_word(d[k], 4'hF, 1'b0, f[k*32 +: 32]);
    drive_word(d[4], 4'hF, 1'b0, f[4*32 +: 32]);
    bus.pt_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_din_stall", bus.din_ready, 1'b0);
      @(posedge clk); #1;
    end
    bus.pt_ready = 1'b1;
    wait_accept();
    for (int k = 5; k < 8; k++) send_word(d[k], 4'hF, 1'b0, f[k*32 +: 32]);
    bus.feed_blck_in = ~f;
    bus.feed_load    = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_dig_hold_vld", bus.dig_blck_valid, 1'b1);
      check("bp_dig_hold_out", bus.dig_blck_out, exp);
      @(posedge clk); #1;
    end
    bus.feed_load = 1'b0;
    finish_digest("bp", exp, 1'b1);
    check("bp_idle_after_ignored_load", bus.din_ready, 1'b0);

    // Reset mid-fill after 4 accepted words
    load_feed({32{8'hAA}});
    for (int k = 0; k < 4; k++) send_word(32'h55555555, 4'hF, 1'b0, 32'hAAAAAAAA);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("mrst_din_ready", bus.din_ready, 1'b0);
    check("mrst_pt_valid", bus.pt_valid, 1'b0);
    check("mrst_pt_out", bus.pt_out, 32'h0);
    check("mrst_pt_validity", bus.pt_validity, 4'h0);
    check("mrst_dig_valid", bus.dig_blck_valid, 1'b0);
    check("mrst_dig_out", bus.dig_blck_out, 256'h0);
    check("mrst_dig_full", bus.dig_blck_full, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_full("rerun");

    repeat (3) @(posedge clk);
    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
